// File: rtl/garbage_attack_scheduler.sv
// Versus-mode garbage scheduler: converts line clears to attack, cancels against own queue, queues the rest
// for the opponent, releases ripe garbage on clear-free locks. Optional combo bonus: define GARB_COMBO_EN.
module garbage_attack_scheduler #(
  parameter int QDEPTH    = 4,
  parameter int DELAY_CYC = 60,
  parameter int MAX_REL   = 8,
  parameter int MAX_PEND  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       p0_lock,
  input  logic [2:0] p0_lines,
  input  logic       p1_lock,
  input  logic [2:0] p1_lines,
  output logic       p0_garb_valid,
  output logic [4:0] p0_garb_lines,
  output logic       p1_garb_valid,
  output logic [4:0] p1_garb_lines,
  output logic [4:0] p0_pending,
  output logic [4:0] p1_pending
);

  localparam int AW = $clog2(DELAY_CYC + 1);
  localparam int CW = $clog2(QDEPTH + 1);

  // Queue p holds garbage pending against player p.
  logic [4:0]    q_lines [2][QDEPTH];
  logic [AW-1:0] q_age   [2][QDEPTH];
  logic [CW-1:0] q_cnt   [2];
  logic [4:0]    pend_q  [2];
  logic          gv_q    [2];
  logic [4:0]    gl_q    [2];

  logic [4:0]    n_lines [2][QDEPTH];
  logic [AW-1:0] n_age   [2][QDEPTH];
  logic [CW-1:0] n_cnt   [2];
  logic [4:0]    n_pend  [2];
  logic          n_gv    [2];
  logic [4:0]    n_gl    [2];

  logic          lock      [2];
  logic [2:0]    lines     [2];
  logic          cancel_en [2];
  logic          release_en[2];
  logic [7:0]    attack    [2];
  logic [7:0]    rem       [2];
  logic [7:0]    total     [2];

`ifdef GARB_COMBO_EN
  logic [3:0] combo_q [2];
  logic [3:0] n_combo [2];
`endif

  assign lock[0]  = p0_lock;
  assign lock[1]  = p1_lock;
  assign lines[0] = p0_lines;
  assign lines[1] = p1_lines;

  always_comb begin
    logic [4:0]    w_lines [QDEPTH];
    logic [7:0]    budget;
    logic [7:0]    take;
    logic [7:0]    sum;
    logic [7:0]    add;
    logic          blocked;
    logic          lead;
    logic [CW-1:0] pops;
    int            src;
    // NOTE: this block only builds next-state values, so blocking '=' is correct here; registers use '<='.
    for (int p = 0; p < 2; p++) begin
      cancel_en[p]  = game_active && lock[p] && (lines[p] != 3'd0);
      release_en[p] = game_active && lock[p] && (lines[p] == 3'd0);
      case (lines[p])
        3'd0, 3'd1: attack[p] = 8'd0;
        3'd2:       attack[p] = 8'd1;
        3'd3:       attack[p] = 8'd2;
        default:    attack[p] = 8'd4;
      endcase
`ifdef GARB_COMBO_EN
      if (combo_q[p] >= 4'd2) attack[p] = attack[p] + 8'd1;
      n_combo[p] = combo_q[p];
      if (cancel_en[p])       n_combo[p] = (combo_q[p] == 4'd15) ? 4'd15 : combo_q[p] + 4'd1;
      else if (release_en[p]) n_combo[p] = 4'd0;
`endif
    end

    // Phase 1: cancel or release against each queue's pre-cycle contents, then compact and age.
    for (int p = 0; p < 2; p++) begin
      budget  = cancel_en[p] ? attack[p] : (release_en[p] ? 8'(MAX_REL) : 8'd0);
      sum     = 8'd0;
      blocked = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        w_lines[i] = q_lines[p][i];
        take       = 8'd0;
        if (i < int'(q_cnt[p]) && !blocked &&
            (cancel_en[p] || (release_en[p] && q_age[p][i] == AW'(DELAY_CYC)))) begin
          take       = (budget < {3'd0, q_lines[p][i]}) ? budget : {3'd0, q_lines[p][i]};
          w_lines[i] = q_lines[p][i] - take[4:0];
          budget     = budget - take;
          sum        = sum + take;
          if (w_lines[i] != 5'd0) blocked = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
      // Consumption is oldest-first, so emptied entries form a prefix of the queue.
      pops = '0;
      lead = 1'b1;
      for (int i = 0; i < QDEPTH; i++) begin
        if (lead && i < int'(q_cnt[p]) && w_lines[i] == 5'd0) pops = pops + 1'b1;
        else lead = 1'b0;
      end
      total[p] = 8'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        src           = i + int'(pops);
        n_lines[p][i] = 5'd0;
        n_age[p][i]   = '0;
        if (src < int'(q_cnt[p])) begin
          n_lines[p][i] = w_lines[src];
          n_age[p][i]   = (q_age[p][src] == AW'(DELAY_CYC)) ? q_age[p][src] : q_age[p][src] + 1'b1;
        end
        total[p] = total[p] + {3'd0, n_lines[p][i]};
      end
      n_cnt[p] = q_cnt[p] - pops;
      rem[p]   = cancel_en[p] ? budget : 8'd0;
      n_gv[p]  = release_en[p];
      n_gl[p]  = release_en[p] ? sum[4:0] : 5'd0;
    end

    // Phase 2: uncancelled attack lands on the opponent's queue after its own cancel/release.
    for (int p = 0; p < 2; p++) begin
      add = 8'(MAX_PEND) - total[p];
      if (rem[1-p] < add) add = rem[1-p];
      if (add != 8'd0) begin
        if (int'(n_cnt[p]) < QDEPTH) begin
          for (int i = 0; i < QDEPTH; i++) begin
            if (i == int'(n_cnt[p])) begin
              n_lines[p][i] = add[4:0];
              n_age[p][i]   = '0;
            end
          end
          n_cnt[p] = n_cnt[p] + 1'b1;
        end else begin
          n_lines[p][QDEPTH-1] = n_lines[p][QDEPTH-1] + add[4:0];
        end
      end
      n_pend[p] = total[p][4:0] + add[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !game_active) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < QDEPTH; i++) begin
          q_lines[p][i] <= 5'd0;
          q_age[p][i]   <= '0;
        end
        q_cnt[p]  <= '0;
        pend_q[p] <= 5'd0;
        gv_q[p]   <= 1'b0;
        gl_q[p]   <= 5'd0;
`ifdef GARB_COMBO_EN
        combo_q[p] <= 4'd0;
`endif
      end
    end else begin
      q_lines <= n_lines;
      q_age   <= n_age;
      q_cnt   <= n_cnt;
      pend_q  <= n_pend;
      gv_q    <= n_gv;
      gl_q    <= n_gl;
`ifdef GARB_COMBO_EN
      combo_q <= n_combo;
`endif
    end
  end

  assign p0_garb_valid = gv_q[0];
  assign p0_garb_lines = gl_q[0];
  assign p1_garb_valid = gv_q[1];
  assign p1_garb_lines = gl_q[1];
  assign p0_pending    = pend_q[0];
  assign p1_pending    = pend_q[1];

endmodule

// File: tb/tb_garbage_attack_scheduler.sv
// Directed bench for garbage_attack_scheduler; expectations are hand-derived from the attack table,
// ripeness delay, release cap and pending saturation.
module tb_garbage_attack_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_active;
  logic       p0_lock, p1_lock;
  logic [2:0] p0_lines, p1_lines;
  logic       p0_garb_valid, p1_garb_valid;
  logic [4:0] p0_garb_lines, p1_garb_lines;
  logic [4:0] p0_pending, p1_pending;

  int n_checks = 0;
  int n_pass   = 0;

  garbage_attack_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .game_active   (game_active),
    .p0_lock       (p0_lock),
    .p0_lines      (p0_lines),
    .p1_lock       (p1_lock),
    .p1_lines      (p1_lines),
    .p0_garb_valid (p0_garb_valid),
    .p0_garb_lines (p0_garb_lines),
    .p1_garb_valid (p1_garb_valid),
    .p1_garb_lines (p1_garb_lines),
    .p0_pending    (p0_pending),
    .p1_pending    (p1_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Drive both lock inputs for one cycle; on return the post-edge (T+1) outputs are visible.
  task automatic lock2(input logic l0, input int n0, input logic l1, input int n1);
    @(negedge clk);
    p0_lock = l0; p0_lines = 3'(n0);
    p1_lock = l1; p1_lines = 3'(n1);
    @(negedge clk);
    p0_lock = 1'b0; p0_lines = 3'd0;
    p1_lock = 1'b0; p1_lines = 3'd0;
  endtask

  // p0 clear followed by a clear-free p0 lock, which keeps the combo counter at zero.
  task automatic p0_hit(input int n);
    lock2(1'b1, n, 1'b0, 0);
    lock2(1'b1, 0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    game_active = 1'b0;
    @(negedge clk);
    game_active = 1'b1;
  endtask

  initial begin
    rst = 1'b1; game_active = 1'b1;
    p0_lock = 1'b0; p0_lines = 3'd0; p1_lock = 1'b0; p1_lines = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_p0_valid", int'(p0_garb_valid), 0);
    check("rst_p1_valid", int'(p1_garb_valid), 0);
    check("rst_p0_glines", int'(p0_garb_lines), 0);
    check("rst_p1_glines", int'(p1_garb_lines), 0);
    check("rst_p0_pend", int'(p0_pending), 0);
    check("rst_p1_pend", int'(p1_pending), 0);
    rst = 1'b0;

    // Tetris sends 4, ripens, released in one piece.
    lock2(1'b1, 4, 1'b0, 0);
    check("t2_p1_pend", int'(p1_pending), 4);
    check("t2_p0_pend", int'(p0_pending), 0);
    idle(65);
    lock2(1'b0, 0, 1'b1, 0);
    check("t2_rel_valid", int'(p1_garb_valid), 1);
    check("t2_rel_lines", int'(p1_garb_lines), 4);
    check("t2_rel_pend", int'(p1_pending), 0);
    check("t2_p0_novalid", int'(p0_garb_valid), 0);
    @(negedge clk);
    check("t2_valid_pulse", int'(p1_garb_valid), 0);
    check("t2_lines_idle", int'(p1_garb_lines), 0);

    // Cancellation of unripe garbage.
    p0_hit(4);
    lock2(1'b0, 0, 1'b1, 3);
    check("t3_p1_pend", int'(p1_pending), 2);
    check("t3_p0_pend", int'(p0_pending), 0);
    check("t3_no_valid", int'(p1_garb_valid), 0);

    // Deassert game_active discards pending.
    flush();
    @(negedge clk);
    check("flush_p1_pend", int'(p1_pending), 0);

    // Ripe {4,2,4}: release caps at 8, head keeps 2 and its ripeness.
    p0_hit(4); p0_hit(3); p0_hit(4);
    check("t4_fill", int'(p1_pending), 10);
    idle(70);
    lock2(1'b0, 0, 1'b1, 0);
    check("t4_rel_lines", int'(p1_garb_lines), 8);
    check("t4_rel_pend", int'(p1_pending), 2);
    lock2(1'b0, 0, 1'b1, 0);
    check("t4_rest_lines", int'(p1_garb_lines), 2);
    check("t4_rest_pend", int'(p1_pending), 0);

    // Unripe head blocks; empty release still pulses valid.
    p0_hit(4);
    idle(70);
    p0_hit(3);
    lock2(1'b0, 0, 1'b1, 0);
    check("blk_lines", int'(p1_garb_lines), 4);
    check("blk_pend", int'(p1_pending), 2);
    lock2(1'b0, 0, 1'b1, 0);
    check("zero_valid", int'(p1_garb_valid), 1);
    check("zero_lines", int'(p1_garb_lines), 0);
    check("zero_pend", int'(p1_pending), 2);

    // Simultaneous locks: both push, then both cancel from pre-cycle contents.
    flush();
    lock2(1'b1, 4, 1'b1, 4);
    check("t5_p0_pend", int'(p0_pending), 4);
    check("t5_p1_pend", int'(p1_pending), 4);
    lock2(1'b1, 3, 1'b1, 3);
    check("t5c_p0_pend", int'(p0_pending), 2);
    check("t5c_p1_pend", int'(p1_pending), 2);

    // Consecutive-cycle locks, lines>4 clamp.
    flush();
    @(negedge clk);
    p0_lock = 1'b1; p0_lines = 3'd4;
    @(negedge clk);
    p0_lines = 3'd3;
    @(negedge clk);
    p0_lock = 1'b0; p0_lines = 3'd0;
    check("consec_pend", int'(p1_pending), 6);
    flush();
    lock2(1'b1, 7, 1'b0, 0);
    check("clamp7_pend", int'(p1_pending), 4);

    // Locks ignored while inactive.
    flush();
    @(negedge clk);
    game_active = 1'b0;
    p0_lock = 1'b1; p0_lines = 3'd4;
    @(negedge clk);
    p0_lock = 1'b0; p0_lines = 3'd0;
    game_active = 1'b1;
    @(negedge clk);
    check("inactive_pend", int'(p1_pending), 0);

    // Full queue merges into tail; saturation at 20.
    for (int k = 1; k <= 5; k++) begin
      p0_hit(4);
      if (k == 4) check("t6_four", int'(p1_pending), 16);
    end
    check("t6_sat", int'(p1_pending), 20);
    p0_hit(4);
    check("t6_sixth", int'(p1_pending), 20);
    idle(70);
    lock2(1'b0, 0, 1'b1, 0);
    check("t6_rel_lines", int'(p1_garb_lines), 8);
    check("t6_rel_pend", int'(p1_pending), 12);

    // Synchronous reset mid-game.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pend", int'(p1_pending), 0);

    // Combo: three consecutive 2-line clears.
    lock2(1'b1, 2, 1'b0, 0);
    check("t7_a", int'(p1_pending), 1);
    lock2(1'b1, 2, 1'b0, 0);
    check("t7_b", int'(p1_pending), 2);
    lock2(1'b1, 2, 1'b0, 0);
`ifdef GARB_COMBO_EN
    check("t7_c", int'(p1_pending), 4);
`else
    check("t7_c", int'(p1_pending), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
